// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution window sequencer.
//   state_t : frame controller states
//   tag_t   : per-beat result tag (valid flag + window-centre coordinate)
package conv_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned RES_W   = 32;
    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } tag_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, addressed by column.
// Read is combinational and returns the old contents of the addressed column,
// so a write on the same cycle turns the buffer into a one-row delay line.
//   clk       : clock
//   we        : write enable (pixel accepted)
//   addr      : current column
//   wr_data   : pixel entering this row slot
//   rd_data_c : pixel stored one row earlier at addr (combinational)
module line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data_c
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Contents are never reset; validity is tracked by the row count upstream.
    assign rd_data_c = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Feeds a KERNEL x KERNEL convolution pipeline from a raster pixel stream and
// tags each pipeline beat so finished results come out with their window centre.
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a frame (ignored unless idle)
//   pix_valid/ready   : pixel stream handshake, pix_data raster-order pixel
//   conv_valid/data   : one column per beat to the convolution pipeline
//   conv_result       : convolution output, CONV_LATENCY beats behind its column
//   res_valid/data/x/y: one-cycle result strobe with window-centre coordinate
//   busy, frame_done  : frame in progress, end-of-frame pulse
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned KERNEL       = 7,
    parameter int unsigned CONV_LATENCY = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [PIX_W-1:0]          pix_data,
    output logic                      conv_valid,
    output logic [PIX_W*KERNEL-1:0]   conv_data,
    input  logic [RES_W-1:0]          conv_result,
    output logic                      res_valid,
    output logic [RES_W-1:0]          res_data,
    output logic [COORD_W-1:0]        res_x,
    output logic [COORD_W-1:0]        res_y,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned CW    = $clog2(CONV_LATENCY + 2);
    localparam int unsigned COL_W = PIX_W * KERNEL;
    localparam int unsigned HALF  = (KERNEL - 1) / 2;

    state_t           state;
    state_t           state_n;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [CW-1:0]    flush_cnt;
    logic             accept_c;
    logic             last_pix_c;
    logic             flush_beat_c;
    logic [PIX_W-1:0] lb_rd [KERNEL-1];
    logic [COL_W-1:0] column_c;
    tag_t             tag_new_c;
    tag_t             tag_in;
    tag_t             tag_pipe [CONV_LATENCY];

    assign accept_c   = pix_valid & pix_ready;
    assign last_pix_c = (x == XW'(IMG_WIDTH - 1)) && (y == YW'(IMG_HEIGHT - 1));

    // Chain of row buffers: buffer k holds row y-1-k at each column.
    genvar k;
    for (k = 0; k < KERNEL - 1; k++) begin : g_lb
        logic [PIX_W-1:0] wr_c;
        if (k == 0) begin : g_first
            assign wr_c = pix_data;
        end else begin : g_next
            assign wr_c = lb_rd[k-1];
        end
        line_buffer #(
            .DEPTH(IMG_WIDTH),
            .AW   (XW)
        ) u_lb (
            .clk      (clk),
            .we       (accept_c),
            .addr     (x),
            .wr_data  (wr_c),
            .rd_data_c(lb_rd[k])
        );
    end

    // Column assembly: oldest row in the top byte, incoming pixel in the bottom.
    always_comb begin
        column_c = '0;
        column_c[PIX_W-1:0] = pix_data;
        for (int i = 0; i < KERNEL - 1; i++) begin
            column_c[PIX_W*(i+1) +: PIX_W] = lb_rd[i];
        end
    end

    // Tag for the window whose last column is the pixel being accepted.
    always_comb begin
        tag_new_c       = '0;
        tag_new_c.valid = (x >= XW'(KERNEL - 1)) && (y >= YW'(KERNEL - 1));
        tag_new_c.x     = COORD_W'(x) - COORD_W'(HALF);
        tag_new_c.y     = COORD_W'(y) - COORD_W'(HALF);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; FLUSH issues CONV_LATENCY zero beats then waits one cycle so
    // the last result strobe precedes frame_done.
    always_comb begin
        state_n      = state;
        flush_beat_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (accept_c && last_pix_c) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                flush_beat_c = (flush_cnt < CW'(CONV_LATENCY));
                if (flush_cnt == CW'(CONV_LATENCY + 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Raster position and flush counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                x <= '0;
                y <= '0;
            end else if (accept_c) begin
                if (x == XW'(IMG_WIDTH - 1)) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + CW'(1) : '0;
        end
    end

    // Registered outputs, beat-aligned tag pipeline and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            conv_valid <= 1'b0;
            conv_data  <= '0;
            tag_in     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_x      <= '0;
            res_y      <= '0;
            for (int i = 0; i < CONV_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            pix_ready  <= (state_n == RUN);
            busy       <= (state_n != IDLE);
            frame_done <= (state_n == DONE);
            conv_valid <= accept_c | flush_beat_c;
            conv_data  <= accept_c ? column_c : '0;
            tag_in     <= accept_c ? tag_new_c : '0;
            // Advances only on beats, in lockstep with the convolution pipeline.
            if (conv_valid) begin
                tag_pipe[0] <= tag_in;
                for (int i = 1; i < CONV_LATENCY; i++) begin
                    tag_pipe[i] <= tag_pipe[i-1];
                end
            end
            res_valid <= conv_valid & tag_pipe[CONV_LATENCY-1].valid;
            if (conv_valid && tag_pipe[CONV_LATENCY-1].valid) begin
                res_data <= conv_result;
                res_x    <= tag_pipe[CONV_LATENCY-1].x;
                res_y    <= tag_pipe[CONV_LATENCY-1].y;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: an 8x8 instance exercised with
// several frames and a 7x7 instance for the single-window boundary case.
module tb_conv_window_sequencer;

    logic        clk;
    logic        reset;

    // 8x8 instance
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        conv_valid;
    logic [55:0] conv_data;
    logic [31:0] conv_result;
    logic        res_valid;
    logic [31:0] res_data;
    logic [15:0] res_x;
    logic [15:0] res_y;
    logic        busy;
    logic        frame_done;

    // 7x7 instance
    logic        start7;
    logic        pix_valid7;
    logic        pix_ready7;
    logic [7:0]  pix_data7;
    logic        conv_valid7;
    logic [55:0] conv_data7;
    logic [31:0] conv_result7;
    logic        res_valid7;
    logic [31:0] res_data7;
    logic [15:0] res_x7;
    logic [15:0] res_y7;
    logic        busy7;
    logic        frame_done7;

    int          checks = 0;
    int          errors = 0;
    int          beat_cnt = 0;
    int          beat7_cnt = 0;
    int          done_cnt = 0;
    int          done7_cnt = 0;
    int          base;
    int          base7;
    logic [63:0] exp_q [$];
    logic [63:0] exp7_q [$];
    logic [63:0] exp_v;
    logic [63:0] exp7_v;

    localparam logic [55:0] COL_66 = 56'h060E161E262E36;

    conv_window_sequencer #(
        .IMG_WIDTH(8), .IMG_HEIGHT(8), .KERNEL(7), .CONV_LATENCY(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .conv_valid(conv_valid), .conv_data(conv_data), .conv_result(conv_result),
        .res_valid(res_valid), .res_data(res_data), .res_x(res_x), .res_y(res_y),
        .busy(busy), .frame_done(frame_done)
    );

    conv_window_sequencer #(
        .IMG_WIDTH(7), .IMG_HEIGHT(7), .KERNEL(7), .CONV_LATENCY(3)
    ) dut7 (
        .clk(clk), .reset(reset), .start(start7),
        .pix_valid(pix_valid7), .pix_ready(pix_ready7), .pix_data(pix_data7),
        .conv_valid(conv_valid7), .conv_data(conv_data7), .conv_result(conv_result7),
        .res_valid(res_valid7), .res_data(res_data7), .res_x(res_x7), .res_y(res_y7),
        .busy(busy7), .frame_done(frame_done7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the convolution pipeline: its output is 0x1000 + beats so far.
    always @(posedge clk) if (conv_valid) beat_cnt <= beat_cnt + 1;
    always @(posedge clk) if (conv_valid7) beat7_cnt <= beat7_cnt + 1;
    assign conv_result  = 32'h1000 + 32'(beat_cnt);
    assign conv_result7 = 32'h1000 + 32'(beat7_cnt);

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    // Result monitors
    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res: got x=%0d y=%0d data=%0h, required no result",
                         res_x, res_y, res_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("res", {res_data, res_x, res_y}, exp_v);
            end
        end
        if (frame_done) begin
            done_cnt++;
            check("results_before_done", 64'(exp_q.size()), 64'd0);
            check("done_not_with_res", 64'(res_valid), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (res_valid7) begin
            if (exp7_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res7: got x=%0d y=%0d data=%0h, required no result",
                         res_x7, res_y7, res_data7);
            end else begin
                exp7_v = exp7_q.pop_front();
                check("res7", {res_data7, res_x7, res_y7}, exp7_v);
            end
        end
        if (frame_done7) done7_cnt++;
    end

    // One 8x8 frame: optional 50% input gaps, optional start pokes, optional abort.
    task automatic run_frame(input bit gaps, input bit poke, input int abort_at);
        int  p;
        int  guard;
        int  flush_beats;
        int  flush_bad;
        bit  prev_acc;
        bit  chk_col;
        bit  got_done;
        bit  quiet_bad;
        p = 0; guard = 0; prev_acc = 0; chk_col = 0;
        @(negedge clk);
        start = 1'b1;
        base  = beat_cnt;
        while (p < 64 && guard < 1000) begin
            @(negedge clk);
            guard++;
            start = poke && (p == 20);
            check("beat_align", 64'(conv_valid), 64'(prev_acc));
            if (chk_col) begin
                check("column_6_6", 64'(conv_data), 64'(COL_66));
                chk_col = 0;
            end
            if (p == abort_at) begin
                pix_valid = 1'b0;
                reset     = 1'b1;
                @(negedge clk);
                check("abort_outputs_zero",
                      64'(|{pix_ready, conv_valid, conv_data, res_valid, res_data,
                            res_x, res_y, busy, frame_done}), 64'd0);
                reset = 1'b0;
                quiet_bad = 0;
                repeat (30) begin
                    @(negedge clk);
                    quiet_bad |= res_valid | frame_done | busy;
                end
                check("abort_quiet", 64'(quiet_bad), 64'd0);
                return;
            end
            pix_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            pix_data  = 8'(p);
            prev_acc  = pix_valid && pix_ready;
            if (prev_acc) begin
                if ((p % 8) >= 6 && (p / 8) >= 6)
                    exp_q.push_back({32'h1000 + 32'(base + p + 3),
                                     16'((p % 8) - 3), 16'((p / 8) - 3)});
                if (p == 54) chk_col = 1;
                p++;
            end
        end
        check("pixels_accepted", 64'(p), 64'd64);
        @(negedge clk);
        pix_valid = 1'b0;
        check("last_pixel_beat", 64'(conv_valid), 64'(prev_acc));
        flush_beats = 0; flush_bad = 0; got_done = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 0);
            if (frame_done) begin
                got_done = 1;
                break;
            end
            if (conv_valid) begin
                flush_beats++;
                if (conv_data != '0) flush_bad++;
            end
        end
        start = 1'b0;
        check("frame_done_seen", 64'(got_done), 64'd1);
        check("flush_beats", 64'(flush_beats), 64'd3);
        check("flush_data_zero", 64'(flush_bad), 64'd0);
        @(negedge clk);
        check("idle_after_done", 64'({busy, pix_ready, frame_done}), 64'd0);
    endtask

    // Single 7x7 frame: exactly one window, centred at (3,3).
    task automatic run7();
        int p;
        int guard;
        bit got_done;
        p = 0; guard = 0; got_done = 0;
        @(negedge clk);
        start7 = 1'b1;
        base7  = beat7_cnt;
        while (p < 49 && guard < 500) begin
            @(negedge clk);
            guard++;
            start7     = 1'b0;
            pix_valid7 = 1'b1;
            pix_data7  = 8'(p);
            if (pix_ready7) begin
                if (p == 48) exp7_q.push_back({32'h1000 + 32'(base7 + 48 + 3), 16'd3, 16'd3});
                p++;
            end
        end
        check("pixels_accepted7", 64'(p), 64'd49);
        @(negedge clk);
        pix_valid7 = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (frame_done7) begin
                got_done = 1;
                break;
            end
        end
        check("frame_done7_seen", 64'(got_done), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        start7 = 1'b0; pix_valid7 = 1'b0; pix_data7 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'(|{pix_ready, conv_valid, conv_data, res_valid, res_data,
                    res_x, res_y, busy, frame_done}), 64'd0);
        check("reset_outputs7",
              64'(|{pix_ready7, conv_valid7, conv_data7, res_valid7, res_data7,
                    res_x7, res_y7, busy7, frame_done7}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(1'b0, 1'b0, -1);   // basic frame
        run_frame(1'b1, 1'b0, -1);   // random input gaps
        run_frame(1'b0, 1'b1, -1);   // start pokes during RUN and FLUSH
        run_frame(1'b0, 1'b0, 40);   // reset mid-frame
        run_frame(1'b1, 1'b1, -1);   // recovery frame
        run7();

        repeat (5) @(negedge clk);
        check("frames_done", 64'(done_cnt), 64'd4);
        check("results_drained", 64'(exp_q.size()), 64'd0);
        check("frames_done7", 64'(done7_cnt), 64'd1);
        check("results_drained7", 64'(exp7_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

endmodule
